// File: rtl/vga_pixel_sink_pkg.sv
// Shared definitions for the VGA pixel sink: screen geometry, framebuffer
// address width, controller states, buffered entry layout and small helpers.
package vga_pixel_sink_pkg;

  localparam int X_SCREEN_PIXELS = 160;
  localparam int Y_SCREEN_PIXELS = 120;
  localparam int FIFO_DEPTH      = 4;
  localparam int ADDR_W          = 15;
  localparam int FB_PIXELS       = X_SCREEN_PIXELS * Y_SCREEN_PIXELS;
  localparam int COLOUR_W        = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [COLOUR_W-1:0] colour;
  } fifo_entry_t;

  // Saturating 8-bit increment used by the optional statistics counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'hFF) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/vga_pixel_sink_pixel_fifo.sv
// Synchronous first-word-fall-through FIFO holding clipped, addressed pixels.
// The head entry is visible combinationally from the storage array, so a word
// pushed on one edge is presented at the head from the following cycle.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module pixel_fifo
  import vga_pixel_sink_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  fifo_entry_t wdata,
  output fifo_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);

  fifo_entry_t   mem_r [DEPTH];
  logic [PW:0]   wr_ptr_r;
  logic [PW:0]   rd_ptr_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Status flags and qualified push/pop derived from the registered pointers.
  always_comb begin
    empty     = (wr_ptr_r == rd_ptr_r);
    full      = (wr_ptr_r[PW] != rd_ptr_r[PW]) &&
                (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
    head      = mem_r[rd_ptr_r[PW-1:0]];
  end

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + {{PW{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{PW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage write; contents are don't-care until a pointer covers them.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[PW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/vga_pixel_sink.sv
// VGA pixel sink: accepts plotter pixel writes, clips them to the screen,
// converts to a linear framebuffer address, buffers them in a small FIFO and
// drains them to a ready/valid memory write port. A clear engine sweeps the
// whole framebuffer with one colour after flushing pending pixels.
// Optional build macro VGA_PIXEL_SINK_CLIP_STATS_EN adds saturating clip/drop
// counters (oClipCount, oDropCount).
module vga_pixel_sink
  import vga_pixel_sink_pkg::*;
#(
  parameter int X_SCREEN_PIXELS = vga_pixel_sink_pkg::X_SCREEN_PIXELS,
  parameter int Y_SCREEN_PIXELS = vga_pixel_sink_pkg::Y_SCREEN_PIXELS,
  parameter int FIFO_DEPTH      = vga_pixel_sink_pkg::FIFO_DEPTH
) (
  input  logic              iClock,
  input  logic              iResetn,
  input  logic [7:0]        iX,
  input  logic [6:0]        iY,
  input  logic [2:0]        iColour,
  input  logic              iPlot,
  input  logic              iClear,
  input  logic [2:0]        iClearColour,
  input  logic              iMemReady,
  output logic              oMemWe,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [2:0]        oMemData,
  output logic              oBusy,
  output logic              oDrop,
  output logic              oClip,
  output logic              oDone,
`ifdef VGA_PIXEL_SINK_CLIP_STATS_EN
  output logic [7:0]        oClipCount,
  output logic [7:0]        oDropCount,
`endif
  output logic [15:0]       oPixelCount
);

  localparam int SCREEN_PIXELS = X_SCREEN_PIXELS * Y_SCREEN_PIXELS;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_PIXELS - 1);

  state_t            state_r;
  logic [ADDR_W-1:0] sweep_addr_r;
  logic [2:0]        clear_colour_r;
  logic [15:0]       pixel_count_r;
  logic              clip_r;
  logic              drop_r;
  logic              done_r;

  fifo_entry_t       fifo_wdata_s;
  fifo_entry_t       fifo_head_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              fifo_pop_s;
  logic              push_s;
  logic              in_range_s;
  logic              clip_s;
  logic              drop_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [2:0]        mem_data_s;
  logic              sweep_xfer_s;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (iClock),
    .rst_n (iResetn),
    .push  (push_s),
    .pop   (fifo_pop_s),
    .wdata (fifo_wdata_s),
    .head  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Memory port source select: clear sweep in CLEAR, FIFO head otherwise.
  always_comb begin
    mem_we_s     = 1'b0;
    mem_addr_s   = '0;
    mem_data_s   = 3'd0;
    fifo_pop_s   = 1'b0;
    sweep_xfer_s = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        mem_we_s     = 1'b1;
        mem_addr_s   = sweep_addr_r;
        mem_data_s   = clear_colour_r;
        sweep_xfer_s = iMemReady;
      end
      ST_IDLE, ST_FLUSH, ST_DONE: begin
        if (!fifo_empty_s) begin
          mem_we_s   = 1'b1;
          mem_addr_s = fifo_head_s.addr;
          mem_data_s = fifo_head_s.colour;
          fifo_pop_s = iMemReady;
        end else begin
          mem_we_s   = 1'b0;
          fifo_pop_s = 1'b0;
        end
      end
      default: begin
        mem_we_s = 1'b0;
      end
    endcase
  end

  // Plot accept rule: clip off-screen pixels, drop when busy or full.
  always_comb begin
    in_range_s = ({24'd0, iX} < 32'(X_SCREEN_PIXELS)) &&
                 ({25'd0, iY} < 32'(Y_SCREEN_PIXELS));
    fifo_wdata_s.addr   = ADDR_W'(iY) * ADDR_W'(X_SCREEN_PIXELS) + ADDR_W'(iX);
    fifo_wdata_s.colour = iColour;
    clip_s = iPlot & ~in_range_s;
    if (iPlot && in_range_s && (state_r == ST_IDLE) &&
        (!fifo_full_s || fifo_pop_s)) begin
      push_s = 1'b1;
      drop_s = 1'b0;
    end else begin
      push_s = 1'b0;
      drop_s = iPlot & in_range_s;
    end
  end

  // Control FSM: IDLE -> FLUSH (drain FIFO) -> CLEAR (sweep) -> DONE -> IDLE.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      state_r        <= ST_IDLE;
      sweep_addr_r   <= '0;
      clear_colour_r <= 3'd0;
      done_r         <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (iClear) begin
            clear_colour_r <= iClearColour;
            state_r        <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (fifo_empty_s) begin
            sweep_addr_r <= '0;
            state_r      <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (sweep_xfer_s) begin
            if (sweep_addr_r == LAST_ADDR) begin
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              sweep_addr_r <= sweep_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Status pulses and the plot-path write counter.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      clip_r        <= 1'b0;
      drop_r        <= 1'b0;
      pixel_count_r <= 16'd0;
    end else begin
      clip_r <= clip_s;
      drop_r <= drop_s;
      if (fifo_pop_s && !fifo_empty_s) begin
        pixel_count_r <= pixel_count_r + 16'd1;
      end
    end
  end

`ifdef VGA_PIXEL_SINK_CLIP_STATS_EN
  logic [7:0] clip_count_r;
  logic [7:0] drop_count_r;

  // Saturating counters of clip and drop events, cleared only by reset.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      clip_count_r <= 8'd0;
      drop_count_r <= 8'd0;
    end else begin
      if (clip_s) begin
        clip_count_r <= sat_inc8(clip_count_r);
      end
      if (drop_s) begin
        drop_count_r <= sat_inc8(drop_count_r);
      end
    end
  end

  assign oClipCount = clip_count_r;
  assign oDropCount = drop_count_r;
`endif

  assign oMemWe      = mem_we_s;
  assign oMemAddr    = mem_addr_s;
  assign oMemData    = mem_data_s;
  assign oBusy       = fifo_full_s | (state_r != ST_IDLE);
  assign oDrop       = drop_r;
  assign oClip       = clip_r;
  assign oDone       = done_r;
  assign oPixelCount = pixel_count_r;

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Directed self-checking bench for vga_pixel_sink.
module tb_vga_pixel_sink;

  logic        iClock = 1'b0;
  logic        iResetn;
  logic [7:0]  iX;
  logic [6:0]  iY;
  logic [2:0]  iColour;
  logic        iPlot;
  logic        iClear;
  logic [2:0]  iClearColour;
  logic        iMemReady;
  logic        oMemWe;
  logic [14:0] oMemAddr;
  logic [2:0]  oMemData;
  logic        oBusy;
  logic        oDrop;
  logic        oClip;
  logic        oDone;
  logic [15:0] oPixelCount;
`ifdef VGA_PIXEL_SINK_CLIP_STATS_EN
  logic [7:0]  oClipCount;
  logic [7:0]  oDropCount;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int exp_count = 0;

  vga_pixel_sink dut (
    .iClock       (iClock),
    .iResetn      (iResetn),
    .iX           (iX),
    .iY           (iY),
    .iColour      (iColour),
    .iPlot        (iPlot),
    .iClear       (iClear),
    .iClearColour (iClearColour),
    .iMemReady    (iMemReady),
    .oMemWe       (oMemWe),
    .oMemAddr     (oMemAddr),
    .oMemData     (oMemData),
    .oBusy        (oBusy),
    .oDrop        (oDrop),
    .oClip        (oClip),
    .oDone        (oDone),
`ifdef VGA_PIXEL_SINK_CLIP_STATS_EN
    .oClipCount   (oClipCount),
    .oDropCount   (oDropCount),
`endif
    .oPixelCount  (oPixelCount)
  );

  always #5 iClock = ~iClock;

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic test_reset();
    iResetn = 1'b0; iX = 8'd0; iY = 7'd0; iColour = 3'd0; iPlot = 1'b0;
    iClear = 1'b0; iClearColour = 3'd0; iMemReady = 1'b0;
    #12;
    n_cmp++;
    if ({oMemWe, oBusy, oDrop, oClip, oDone} !== 5'b00000) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 00000", {oMemWe, oBusy, oDrop, oClip, oDone});
    end
    n_cmp++;
    if (oMemAddr !== 15'd0 || oMemData !== 3'd0 || oPixelCount !== 16'd0) begin
      n_bad++; $display("FAIL reset_data: got addr %0d data %0d cnt %0d expected 0 0 0", oMemAddr, oMemData, oPixelCount);
    end
    @(negedge iClock);
    iResetn = 1'b1;
    tick();
  endtask

  task automatic test_plot();
    iMemReady = 1'b1; iX = 8'd5; iY = 7'd2; iColour = 3'd3; iPlot = 1'b1;
    tick();
    iPlot = 1'b0;
    n_cmp++;
    if (oMemWe !== 1'b1 || oMemAddr !== 15'd325 || oMemData !== 3'd3) begin
      n_bad++; $display("FAIL plot_write: got we %b addr %0d data %0d expected 1 325 3", oMemWe, oMemAddr, oMemData);
    end
    tick();
    exp_count++;
    n_cmp++;
    if (oPixelCount !== 16'(exp_count) || oMemWe !== 1'b0) begin
      n_bad++; $display("FAIL plot_count: got cnt %0d we %b expected %0d 0", oPixelCount, oMemWe, exp_count);
    end
  endtask

  task automatic test_clip();
    iPlot = 1'b1; iX = 8'd160; iY = 7'd0; iColour = 3'd1;
    tick();
    n_cmp++;
    if (oClip !== 1'b1 || oMemWe !== 1'b0) begin
      n_bad++; $display("FAIL clip_x: got clip %b we %b expected 1 0", oClip, oMemWe);
    end
    iX = 8'd0; iY = 7'd120;
    tick();
    n_cmp++;
    if (oClip !== 1'b1 || oMemWe !== 1'b0) begin
      n_bad++; $display("FAIL clip_y: got clip %b we %b expected 1 0", oClip, oMemWe);
    end
    iX = 8'd159; iY = 7'd119; iColour = 3'd7;
    tick();
    n_cmp++;
    if (oClip !== 1'b0 || oMemWe !== 1'b1 || oMemAddr !== 15'd19199 || oMemData !== 3'd7) begin
      n_bad++; $display("FAIL corner_pixel: got clip %b we %b addr %0d data %0d expected 0 1 19199 7", oClip, oMemWe, oMemAddr, oMemData);
    end
    iPlot = 1'b0;
    tick();
    exp_count++;
    n_cmp++;
    if (oPixelCount !== 16'(exp_count)) begin
      n_bad++; $display("FAIL clip_count: got %0d expected %0d", oPixelCount, exp_count);
    end
  endtask

  task automatic test_fifo_full();
    iMemReady = 1'b0; iY = 7'd0; iPlot = 1'b1;
    for (int i = 0; i < 5; i++) begin
      iX = 8'(i); iColour = 3'(i);
      tick();
      if (i == 2) begin
        n_cmp++;
        if (oBusy !== 1'b0) begin n_bad++; $display("FAIL busy_partial: got %b expected 0", oBusy); end
      end
      if (i == 3) begin
        n_cmp++;
        if (oBusy !== 1'b1 || oDrop !== 1'b0) begin
          n_bad++; $display("FAIL busy_full: got busy %b drop %b expected 1 0", oBusy, oDrop);
        end
      end
    end
    n_cmp++;
    if (oDrop !== 1'b1) begin n_bad++; $display("FAIL drop_full: got %b expected 1", oDrop); end
    iPlot = 1'b0;
    tick();
    n_cmp++;
    if (oDrop !== 1'b0 || oMemWe !== 1'b1 || oMemAddr !== 15'd0) begin
      n_bad++; $display("FAIL stall_hold: got drop %b we %b addr %0d expected 0 1 0", oDrop, oMemWe, oMemAddr);
    end
    iMemReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (oMemWe !== 1'b1 || oMemAddr !== 15'(k) || oMemData !== 3'(k)) begin
        n_bad++; $display("FAIL drain_order: got we %b addr %0d data %0d expected 1 %0d %0d", oMemWe, oMemAddr, oMemData, k, k);
      end
      tick();
      exp_count++;
    end
    n_cmp++;
    if (oMemWe !== 1'b0 || oPixelCount !== 16'(exp_count) || oBusy !== 1'b0) begin
      n_bad++; $display("FAIL drain_end: got we %b cnt %0d busy %b expected 0 %0d 0", oMemWe, oPixelCount, oBusy, exp_count);
    end
  endtask

  task automatic test_back_to_back();
    int exp_addr [10];
    int idx = 0;
    int errs = 0;
    for (int i = 0; i < 4; i++) exp_addr[i] = 170 + i;
    for (int i = 0; i < 6; i++) exp_addr[4 + i] = 180 + i;
    iMemReady = 1'b0; iY = 7'd1; iColour = 3'd1; iPlot = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iX = 8'(10 + i);
      tick();
    end
    iMemReady = 1'b1;
    for (int j = 0; j < 6; j++) begin
      iX = 8'(20 + j);
      if (oMemWe !== 1'b1 || oMemAddr !== 15'(exp_addr[idx])) errs++;
      idx++;
      tick();
      exp_count++;
      if (oDrop !== 1'b0) errs++;
    end
    iPlot = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (oMemWe !== 1'b1 || oMemAddr !== 15'(exp_addr[idx])) errs++;
      idx++;
      tick();
      exp_count++;
    end
    n_cmp++;
    if (errs !== 0) begin n_bad++; $display("FAIL back_to_back: got %0d bad cycles expected 0", errs); end
    n_cmp++;
    if (oMemWe !== 1'b0 || oPixelCount !== 16'(exp_count)) begin
      n_bad++; $display("FAIL b2b_end: got we %b cnt %0d expected 0 %0d", oMemWe, oPixelCount, exp_count);
    end
  endtask

  task automatic test_clear();
    int e = 0;
    int errs = 0;
    int dones = 0;
    iMemReady = 1'b1; iX = 8'd1; iY = 7'd1; iColour = 3'd2; iPlot = 1'b1;
    iClear = 1'b1; iClearColour = 3'd0;
    tick();
    iPlot = 1'b0; iClear = 1'b0; iClearColour = 3'd6;
    n_cmp++;
    if (oMemWe !== 1'b1 || oMemAddr !== 15'd161 || oMemData !== 3'd2 || oBusy !== 1'b1) begin
      n_bad++; $display("FAIL clear_first_pixel: got we %b addr %0d data %0d busy %b expected 1 161 2 1", oMemWe, oMemAddr, oMemData, oBusy);
    end
    tick();
    exp_count++;
    for (int c = 0; c < 20000 && e < 19200; c++) begin
      if (oDone === 1'b1) dones++;
      if (oMemWe === 1'b1) begin
        if (oMemAddr !== 15'(e) || oMemData !== 3'd0) errs++;
        e++;
      end
      tick();
    end
    n_cmp++;
    if (e !== 19200 || errs !== 0 || dones !== 0) begin
      n_bad++; $display("FAIL clear_sweep: got %0d writes %0d bad %0d early done expected 19200 0 0", e, errs, dones);
    end
    n_cmp++;
    if (oDone !== 1'b1 || oMemWe !== 1'b0) begin
      n_bad++; $display("FAIL clear_done: got done %b we %b expected 1 0", oDone, oMemWe);
    end
    tick();
    n_cmp++;
    if (oDone !== 1'b0 || oBusy !== 1'b0 || oPixelCount !== 16'(exp_count)) begin
      n_bad++; $display("FAIL clear_end: got done %b busy %b cnt %0d expected 0 0 %0d", oDone, oBusy, oPixelCount, exp_count);
    end
  endtask

  task automatic test_reset_mid_clear();
    int c = 0;
    iMemReady = 1'b1; iClear = 1'b1; iClearColour = 3'd5;
    tick();
    iClear = 1'b0;
    while (c < 1000 && !(oMemWe === 1'b1 && oMemAddr === 15'd500)) begin
      tick();
      c++;
    end
    n_cmp++;
    if (oMemAddr !== 15'd500 || oMemData !== 3'd5) begin
      n_bad++; $display("FAIL reach_500: got addr %0d data %0d expected 500 5", oMemAddr, oMemData);
    end
    iPlot = 1'b1; iX = 8'd3; iY = 7'd0; iColour = 3'd4;
    tick();
    iPlot = 1'b0;
    n_cmp++;
    if (oDrop !== 1'b1 || oMemAddr !== 15'd501) begin
      n_bad++; $display("FAIL drop_in_clear: got drop %b addr %0d expected 1 501", oDrop, oMemAddr);
    end
`ifdef VGA_PIXEL_SINK_CLIP_STATS_EN
    n_cmp++;
    if (oClipCount !== 8'd2 || oDropCount !== 8'd2) begin
      n_bad++; $display("FAIL stats: got clip %0d drop %0d expected 2 2", oClipCount, oDropCount);
    end
`endif
    iResetn = 1'b0;
    #1;
    n_cmp++;
    if (oMemWe !== 1'b0 || oBusy !== 1'b0 || oPixelCount !== 16'd0 || oDrop !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_clear: got we %b busy %b cnt %0d drop %b expected 0 0 0 0", oMemWe, oBusy, oPixelCount, oDrop);
    end
    #2;
    iResetn = 1'b1;
    iPlot = 1'b1; iX = 8'd2; iY = 7'd0; iColour = 3'd1;
    tick();
    iPlot = 1'b0;
    n_cmp++;
    if (oMemWe !== 1'b1 || oMemAddr !== 15'd2 || oMemData !== 3'd1 || oBusy !== 1'b0) begin
      n_bad++; $display("FAIL after_reset_plot: got we %b addr %0d data %0d busy %b expected 1 2 1 0", oMemWe, oMemAddr, oMemData, oBusy);
    end
    tick();
    n_cmp++;
    if (oPixelCount !== 16'd1) begin
      n_bad++; $display("FAIL after_reset_count: got %0d expected 1", oPixelCount);
    end
  endtask

  initial begin
    test_reset();
    test_plot();
    test_clip();
    test_fifo_full();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
